decrypt_lanes: RTL and testbench

//  Parametrised multi-lane iterative decryptor: generalises the fixed 4-byte, 3-key decrypt core.

---
 rtl/decrypt_pkg.sv | 35 +++
 rtl/decrypt_round.sv | 25 ++
 rtl/decrypt_lanes.sv | 108 ++++++++++
 tb/tb_decrypt_lanes.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_pkg
// Description : Shared types and helpers for the multi-lane iterative
//               decryptor (FSM state encoding, rotate-right-by-one, lane
//               bit offset).
// Revision    : 1.0 - initial release
// ============================================================================
package decrypt_pkg;

  // Widest word the rotate helper can handle; callers zero-extend into it.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Rotate the low w bits of x right by one. Upper bits of x must be zero.
  function automatic logic [MAXW-1:0] rotr1(input logic [MAXW-1:0] x,
                                            input int unsigned     w);
    logic [MAXW-1:0] lsb;
    lsb = {{(MAXW-1){1'b0}}, x[0]};
    return (x >> 1) | (lsb << (w - 1));
  endfunction

  // Bit offset of lane idx inside a packed block of w-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned idx,
                                          input int unsigned w);
    return idx * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decrypt_round.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_round
// Description : One decrypt round for one lane (combinational):
//               x_o = rotr1(x_i) ^ ((key_i + lane_i) mod 2^W).
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_round
  import decrypt_pkg::*;
#(
  parameter int W = 8   // 2..MAXW
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] key_i,
  input  logic [W-1:0] lane_i,
  output logic [W-1:0] x_o
);

  // Key plus lane offset wraps naturally in W bits.
  always_comb begin
    x_o = W'(rotr1(MAXW'(x_i), W)) ^ (key_i + lane_i);
  end

endmodule
`default_nettype wire

// File: rtl/decrypt_lanes.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_lanes
// Description : Multi-lane iterative decryptor. Accepts LANES ciphertext
//               words per block, applies ROUNDS key rounds (one per clock,
//               keys used from index ROUNDS-1 down to 0), and presents the
//               plaintext with a valid/ready handshake. Key file is writable
//               only while idle; writes at other times set a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_lanes
  import decrypt_pkg::*;
#(
  parameter  int LANES  = 4,
  parameter  int W      = 8,
  parameter  int ROUNDS = 3,
  localparam int KA     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               KEY_WE,
  input  logic [KA-1:0]      KEY_ADDR,
  input  logic [W-1:0]       KEY_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [LANES*W-1:0] IN_DATA,
  output logic               EN,
  input  logic               OUT_READY,
  output logic [LANES*W-1:0] OUT_DATA,
  output logic               KEY_ERR
);

  localparam logic [KA:0]   ROUNDS_C = (KA+1)'(ROUNDS);
  localparam logic [KA-1:0] LAST_R_C = KA'(ROUNDS - 1);

  state_e               state_q, state_d;
  logic [KA-1:0]        r_q;
  logic [LANES*W-1:0]   data_q;
  logic [W-1:0]         key_q [ROUNDS];
  logic                 key_err_q;

  logic [LANES*W-1:0]   round_w;
  logic [W-1:0]         key_w;
  logic                 accept_w;
  logic                 key_ok_w;

  assign accept_w = (state_q == IDLE) && IN_VALID;
  assign key_ok_w = KEY_WE && (state_q == IDLE) && ({1'b0, KEY_ADDR} < ROUNDS_C);
  // Keys are read live each round; the write protection outside IDLE keeps
  // them constant for the whole block.
  assign key_w    = key_q[r_q];

  assign IN_READY = (state_q == IDLE);
  assign EN       = (state_q == DONE);
  assign OUT_DATA = data_q;
  assign KEY_ERR  = key_err_q;

  // One round instance per lane; all lanes share the current key.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [W-1:0] LANE_C = W'(i);
    decrypt_round #(.W(W)) u_round (
      .x_i    (data_q[lane_lo(i, W) +: W]),
      .key_i  (key_w),
      .lane_i (LANE_C),
      .x_o    (round_w[lane_lo(i, W) +: W])
    );
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept -> ROUNDS round cycles -> wait for consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (IN_VALID)    state_d = RUN;
      RUN:     if (r_q == '0)   state_d = DONE;
      DONE:    if (OUT_READY)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Datapath, round counter, key file and sticky key-error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q    <= '0;
      r_q       <= '0;
      key_err_q <= 1'b0;
      for (int k = 0; k < ROUNDS; k++) key_q[k] <= '0;
    end else begin
      if (key_ok_w) key_q[KEY_ADDR] <= KEY_DATA;
      if (KEY_WE && (state_q != IDLE)) key_err_q <= 1'b1;

      if (accept_w) begin
        data_q <= IN_DATA;
        r_q    <= LAST_R_C;
      end else if (state_q == RUN) begin
        data_q <= round_w;
        if (r_q != '0) r_q <= r_q - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_decrypt_lanes
// Description : Self-checking bench for decrypt_lanes (LANES=4, W=8,
//               ROUNDS=3) with a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decrypt_lanes;

  localparam int LANES  = 4;
  localparam int W      = 8;
  localparam int ROUNDS = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        KEY_WE;
  logic [1:0]  KEY_ADDR;
  logic [7:0]  KEY_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        EN;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic        KEY_ERR;

  int checks = 0;
  int errors = 0;
  int mk [ROUNDS];      // model key file
  bit merr = 1'b0;      // model sticky error

  always #5 CLK = ~CLK;

  decrypt_lanes #(.LANES(LANES), .W(W), .ROUNDS(ROUNDS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .KEY_WE   (KEY_WE),
    .KEY_ADDR (KEY_ADDR),
    .KEY_DATA (KEY_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .EN       (EN),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .KEY_ERR  (KEY_ERR)
  );

  // Reference: per lane, rounds with key index ROUNDS-1 down to 0,
  // x = rotate-right-1(x) xor ((K[r] + lane) mod 256).
  function automatic logic [31:0] ref_dec(input logic [31:0] c);
    logic [31:0] res;
    int x;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'(c[i*8 +: 8]);
      for (int r = ROUNDS - 1; r >= 0; r--) begin
        x = (x / 2) + (x % 2) * 128;
        x = x ^ ((mk[r] + i) % 256);
      end
      res[i*8 +: 8] = 8'(x);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_key(input logic [1:0] a, input logic [7:0] d);
    KEY_WE = 1'b1; KEY_ADDR = a; KEY_DATA = d;
    @(negedge CLK);
    KEY_WE = 1'b0;
    if (int'(a) < ROUNDS) mk[a] = int'(d);
  endtask

  // Send one block; optionally poke a key during RUN and/or stall the consumer.
  task automatic run_block(input logic [31:0] c, input int hold, input bit key_in_run,
                           input string tag, output logic [31:0] got);
    logic [31:0] exp;
    int n;
    exp = ref_dec(c);
    check({tag, "_ready"}, 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1; IN_DATA = c;
    @(negedge CLK);
    IN_VALID = 1'b0; IN_DATA = $urandom;
    check({tag, "_en_early"}, 32'(EN), 32'd0);
    n = 0;
    while (!EN && n < 20) begin
      if (n == 0 && key_in_run) begin
        KEY_WE = 1'b1; KEY_ADDR = 2'd0; KEY_DATA = 8'($urandom);
        merr = 1'b1;
      end
      @(negedge CLK);
      KEY_WE = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(ROUNDS));
    check({tag, "_data"}, OUT_DATA, exp);
    check({tag, "_keyerr"}, 32'(KEY_ERR), 32'(merr));
    got = OUT_DATA;
    if (hold > 0) begin
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      for (int h = 0; h < hold; h++) begin
        IN_DATA = $urandom;
        @(negedge CLK);
        check({tag, "_hold_en"}, 32'(EN), 32'd1);
        check({tag, "_hold_data"}, OUT_DATA, exp);
        check({tag, "_hold_rdy"}, 32'(IN_READY), 32'd0);
      end
      IN_VALID = 1'b0;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check({tag, "_en_drop"}, 32'(EN), 32'd0);
    check({tag, "_idle"}, 32'(IN_READY), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] q [$];
    logic [31:0] e;
    int pushed, popped, cyc, last;

    RST = 1'b1; KEY_WE = 1'b0; KEY_ADDR = '0; KEY_DATA = '0;
    IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    for (int k = 0; k < ROUNDS; k++) mk[k] = 0;

    // Reset for two cycles.
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_ready", 32'(IN_READY), 32'd1);
    check("rst_en", 32'(EN), 32'd0);
    check("rst_data", OUT_DATA, 32'd0);
    check("rst_keyerr", 32'(KEY_ERR), 32'd0);

    // Known-answer block.
    write_key(2'd0, 8'h01);
    write_key(2'd1, 8'h02);
    write_key(2'd2, 8'h03);
    run_block(32'h0, 0, 1'b0, "kat", got);
    check("kat_lane0", 32'(got[7:0]), 32'hC0);
    check("kat_lane1", 32'(got[15:8]), 32'h82);

    // Consumer backpressure with input offered during DONE.
    run_block($urandom, 10, 1'b0, "bp", got);

    // Key write during RUN is dropped and flagged.
    run_block(32'h0, 0, 1'b1, "kwrun", got);
    check("kwrun_lanes", 32'(got[15:0]), 32'h82C0);
    // Out-of-range key address in IDLE is ignored.
    write_key(2'd3, 8'h55);
    run_block(32'h0, 0, 1'b0, "kwaddr3", got);
    check("kwaddr3_lanes", 32'(got[15:0]), 32'h82C0);

    // Random keys and blocks.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < ROUNDS; k++) write_key(2'(k), 8'($urandom));
      run_block($urandom, int'($urandom_range(0, 2)), 1'b0, "rand", got);
    end

    // Reset in the middle of RUN.
    IN_VALID = 1'b1; IN_DATA = $urandom;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < ROUNDS; k++) mk[k] = 0;
    merr = 1'b0;
    check("midrst_ready", 32'(IN_READY), 32'd1);
    check("midrst_en", 32'(EN), 32'd0);
    check("midrst_data", OUT_DATA, 32'd0);
    check("midrst_keyerr", 32'(KEY_ERR), 32'd0);
    run_block(32'h0, 0, 1'b0, "zerokey", got);

    // Back-to-back blocks with IN_VALID held and consumer always ready.
    pushed = 0; popped = 0; cyc = 0; last = -1;
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = $urandom;
    while (popped < 4 && cyc < 200) begin
      if (EN) begin
        e = (q.size() > 0) ? q.pop_front() : ~OUT_DATA;
        check("b2b_data", OUT_DATA, e);
        if (last >= 0) check("b2b_gap", 32'(cyc - last), 32'(ROUNDS + 2));
        last = cyc;
        popped++;
      end
      if (IN_READY && IN_VALID) begin
        q.push_back(ref_dec(IN_DATA));
        pushed++;
      end
      @(negedge CLK);
      cyc++;
      if (pushed == 4) IN_VALID = 1'b0;
      IN_DATA = $urandom;
    end
    check("b2b_count", 32'(popped), 32'd4);
    OUT_READY = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
